// File: rtl/rtds_tx_frame_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rtds_tx_frame_pkg
//  Description : Shared word width and frame FSM encoding for the TX framer.
//  Revision    : 1.0 - initial release
// ============================================================================
package rtds_tx_frame_pkg;

    localparam int c_WORD_W  = 32;
    localparam int c_STATE_W = 2;

    localparam logic [c_STATE_W-1:0] c_ST_IDLE  = 2'd0;
    localparam logic [c_STATE_W-1:0] c_ST_DELAY = 2'd1;
    localparam logic [c_STATE_W-1:0] c_ST_SEND  = 2'd2;

endpackage
`default_nettype wire

// File: rtl/rtds_frame_buf.sv
`default_nettype none
// ============================================================================
//  Module      : rtds_frame_buf
//  Description : Two-bank frame buffer, sync write / async read; addr MSB = bank.
//  Revision    : 1.0 - initial release
// ============================================================================
module rtds_frame_buf
    import rtds_tx_frame_pkg::*;
#(
    parameter int MAX_WORDS = 64,
    parameter int AW        = 6
) (
    input  logic                clk,
    input  logic                i_wr_en,
    input  logic [AW:0]         i_wr_addr,
    input  logic [c_WORD_W-1:0] i_wr_data,
    input  logic [AW:0]         i_rd_addr,
    output logic [c_WORD_W-1:0] o_rd_data
);

    logic [c_WORD_W-1:0] r_mem [2*MAX_WORDS];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule
`default_nettype wire

// File: rtl/rtds_tx_frame.sv
`default_nettype none
// ============================================================================
//  Module      : rtds_tx_frame
//  Description : Triggered, delayed AXI-Stream frame sender with double-buffered
//                frame storage toward an Aurora TX user port.
//  Revision    : 1.0 - initial release
// ============================================================================
module rtds_tx_frame
    import rtds_tx_frame_pkg::*;
#(
    parameter int MAX_WORDS = 64,
    parameter int AW        = 6
) (
    input  logic                m_axis_aclk,
    input  logic                sys_reset,
    input  logic                trigger,
    input  logic [AW:0]         cfg_len,
    input  logic [15:0]         cfg_delay,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [c_WORD_W-1:0] wr_data,
    input  logic                wr_commit,
    output logic                m_axis_tvalid,
    output logic [c_WORD_W-1:0] m_axis_tdata,
    output logic                m_axis_tlast,
    input  logic                m_axis_tready,
    output logic                busy,
    output logic [31:0]         frame_count,
    output logic [15:0]         overrun_count,
    output logic                commit_pending
);

    localparam logic [AW:0] c_MAX_LEN = (AW+1)'(MAX_WORDS);

    logic [c_STATE_W-1:0] r_state;
    logic [c_STATE_W-1:0] w_state_next;
    logic [AW:0]          r_len;
    logic [15:0]          r_dly;
    logic [AW-1:0]        r_idx;
    logic                 r_active;
    logic                 r_pending;
    logic [31:0]          r_frame_cnt;
    logic [15:0]          r_overrun;

    logic                 w_idle;
    logic                 w_send;
    logic                 w_start;
    logic                 w_hs;
    logic                 w_last;
    logic                 w_swap;
    logic                 w_wr_bank;
    logic [AW:0]          w_len_clip;
    logic [c_WORD_W-1:0]  w_rd_data;

    assign w_idle     = (r_state == c_ST_IDLE);
    assign w_send     = (r_state == c_ST_SEND);
    assign w_start    = w_idle && trigger && (cfg_len != '0);
    assign w_last     = ({1'b0, r_idx} == (r_len - (AW+1)'(1)));
    assign w_hs       = w_send && m_axis_tready;
    assign w_len_clip = (cfg_len > c_MAX_LEN) ? c_MAX_LEN : cfg_len;

    // Swap in any idle cycle (incl. a frame start) or on the closing handshake,
    // so the new bank is live from the first cycle after tlast.
    assign w_swap    = (r_pending || wr_commit) && (w_idle || (w_hs && w_last));
    assign w_wr_bank = w_swap ? r_active : ~r_active;

    always_ff @(posedge m_axis_aclk or posedge sys_reset) begin
        if (sys_reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_start) begin
                    w_state_next = (cfg_delay == 16'd0) ? c_ST_SEND : c_ST_DELAY;
                end
            end
            c_ST_DELAY: begin
                if (r_dly == 16'd1) begin
                    w_state_next = c_ST_SEND;
                end
            end
            c_ST_SEND: begin
                if (w_hs && w_last) begin
                    w_state_next = c_ST_IDLE;
                end
            end
            default: w_state_next = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge m_axis_aclk or posedge sys_reset) begin
        if (sys_reset) begin
            r_len       <= '0;
            r_dly       <= '0;
            r_idx       <= '0;
            r_active    <= 1'b0;
            r_pending   <= 1'b0;
            r_frame_cnt <= '0;
            r_overrun   <= '0;
        end else begin
            if (w_start) begin
                r_len <= w_len_clip;
                r_dly <= cfg_delay;
            end else if (r_state == c_ST_DELAY) begin
                r_dly <= r_dly - 16'd1;
            end

            if (w_start) begin
                r_idx <= '0;
            end else if (w_hs) begin
                r_idx <= w_last ? '0 : r_idx + AW'(1);
            end

            if (w_hs && w_last) begin
                r_frame_cnt <= r_frame_cnt + 32'd1;
            end

            if (trigger && !w_idle && (r_overrun != 16'hFFFF)) begin
                r_overrun <= r_overrun + 16'd1;
            end

            if (w_swap) begin
                r_active  <= ~r_active;
                r_pending <= 1'b0;
            end else if (wr_commit) begin
                r_pending <= 1'b1;
            end
        end
    end

    rtds_frame_buf #(
        .MAX_WORDS (MAX_WORDS),
        .AW        (AW)
    ) u_buf (
        .clk       (m_axis_aclk),
        .i_wr_en   (wr_en),
        .i_wr_addr ({w_wr_bank, wr_addr}),
        .i_wr_data (wr_data),
        .i_rd_addr ({r_active, r_idx}),
        .o_rd_data (w_rd_data)
    );

    assign m_axis_tvalid  = w_send;
    assign m_axis_tlast   = w_send && w_last;
    assign m_axis_tdata   = w_send ? w_rd_data : '0;
    assign busy           = !w_idle;
    assign frame_count    = r_frame_cnt;
    assign overrun_count  = r_overrun;
    assign commit_pending = r_pending;

endmodule
`default_nettype wire

// File: tb/tb_rtds_tx_frame.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rtds_tx_frame
//  Description : Directed self-checking bench for rtds_tx_frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rtds_tx_frame;

    localparam int MAX_WORDS = 64;
    localparam int AW        = 6;

    logic          clk = 1'b0;
    logic          sys_reset;
    logic          trigger;
    logic [AW:0]   cfg_len;
    logic [15:0]   cfg_delay;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data;
    logic          wr_commit;
    logic          m_axis_tvalid;
    logic [31:0]   m_axis_tdata;
    logic          m_axis_tlast;
    logic          m_axis_tready;
    logic          busy;
    logic [31:0]   frame_count;
    logic [15:0]   overrun_count;
    logic          commit_pending;

    int            n_vec = 0;
    int            n_err = 0;
    logic [31:0]   exp_w [8];

    always #5 clk = ~clk;

    rtds_tx_frame #(.MAX_WORDS(MAX_WORDS), .AW(AW)) dut (
        .m_axis_aclk    (clk),
        .sys_reset      (sys_reset),
        .trigger        (trigger),
        .cfg_len        (cfg_len),
        .cfg_delay      (cfg_delay),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .wr_commit      (wr_commit),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tlast   (m_axis_tlast),
        .m_axis_tready  (m_axis_tready),
        .busy           (busy),
        .frame_count    (frame_count),
        .overrun_count  (overrun_count),
        .commit_pending (commit_pending)
    );

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input int addr, input logic [31:0] data);
        wr_en   = 1'b1;
        wr_addr = AW'(addr);
        wr_data = data;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic commit();
        wr_commit = 1'b1;
        tick();
        wr_commit = 1'b0;
    endtask

    task automatic fire();
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
    endtask

    // Consume one frame starting in the current cycle; optional stall window
    // and up to two stray triggers, all relative to the first consumed cycle.
    task automatic collect(input int n_exp, input int stall_at, input int stall_n,
                           input int trig_a, input int trig_b);
        int  got  = 0;
        bit  done = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            m_axis_tready = !(c >= stall_at && c < stall_at + stall_n);
            trigger       = (c == trig_a) || (c == trig_b);
            #1;
            if (m_axis_tvalid && got < n_exp) begin
                if (!m_axis_tready) begin
                    check_vec("hold", m_axis_tdata, exp_w[got]);
                end else begin
                    check_vec("word", m_axis_tdata, exp_w[got]);
                    if (m_axis_tlast) begin
                        check_vec("tlast_pos", 32'(got), 32'(n_exp - 1));
                        done = 1;
                    end
                    got++;
                end
            end
            @(posedge clk);
            #1;
        end
        trigger       = 1'b0;
        m_axis_tready = 1'b1;
        check_vec("word_count", 32'(got), 32'(n_exp));
        check_vec("done", 32'(done), 32'd1);
    endtask

    initial begin
        int first_v;
        int busy_n;

        sys_reset = 1'b1; trigger = 1'b0; cfg_len = '0; cfg_delay = '0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_commit = 1'b0;
        m_axis_tready = 1'b1;
        repeat (3) tick();
        check_vec("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        check_vec("rst_busy", 32'(busy), 32'd0);
        check_vec("rst_frames", frame_count, 32'd0);
        check_vec("rst_overrun", 32'(overrun_count), 32'd0);
        check_vec("rst_pending", 32'(commit_pending), 32'd0);
        sys_reset = 1'b0;
        tick();

        // Basic frame, no delay
        for (int i = 0; i < 4; i++) write_word(i, 32'(i + 1));
        commit();
        cfg_len = 7'd4; cfg_delay = 16'd0;
        for (int i = 0; i < 4; i++) exp_w[i] = 32'(i + 1);
        fire();
        collect(4, 99, 0, 99, 99);
        check_vec("f1_tvalid_after", 32'(m_axis_tvalid), 32'd0);
        check_vec("f1_frames", frame_count, 32'd1);

        // Delay of 10 cycles
        cfg_delay = 16'd10;
        fire();
        first_v = 0;
        busy_n  = 0;
        for (int k = 1; k <= 20; k++) begin
            if (busy) busy_n++;
            if (m_axis_tvalid && first_v == 0) first_v = k;
            tick();
        end
        check_vec("dly_first_tvalid", 32'(first_v), 32'd11);
        check_vec("dly_busy_cycles", 32'(busy_n), 32'd14);
        check_vec("dly_frames", frame_count, 32'd2);

        // Backpressure for 3 cycles on word 2
        cfg_delay = 16'd0;
        fire();
        collect(4, 1, 3, 99, 99);
        check_vec("bp_frames", frame_count, 32'd3);

        // Two triggers while sending
        fire();
        collect(4, 99, 0, 1, 2);
        repeat (3) begin
            check_vec("ovr_idle", 32'(m_axis_tvalid), 32'd0);
            tick();
        end
        check_vec("ovr_count", 32'(overrun_count), 32'd2);
        check_vec("ovr_frames", frame_count, 32'd4);

        // Commit new data while a frame is in flight
        cfg_delay = 16'd8;
        fire();
        for (int i = 0; i < 4; i++) write_word(i, 32'hA0 + 32'(i));
        commit();
        check_vec("cm_pending", 32'(commit_pending), 32'd1);
        repeat (3) tick();
        collect(4, 99, 0, 99, 99);
        check_vec("cm_pending_clr", 32'(commit_pending), 32'd0);
        check_vec("cm_frames", frame_count, 32'd5);
        cfg_delay = 16'd0;
        for (int i = 0; i < 4; i++) exp_w[i] = 32'hA0 + 32'(i);
        fire();
        collect(4, 99, 0, 99, 99);
        check_vec("cm2_frames", frame_count, 32'd6);

        // Put 0xB.. in bank 1, then reset mid-frame
        for (int i = 0; i < 4; i++) write_word(i, 32'hB0 + 32'(i));
        commit();
        fire();
        check_vec("rs_w0", m_axis_tdata, 32'hB0);
        tick();
        check_vec("rs_w1", m_axis_tdata, 32'hB1);
        sys_reset = 1'b1;
        #1;
        check_vec("rs_tvalid", 32'(m_axis_tvalid), 32'd0);
        check_vec("rs_tlast", 32'(m_axis_tlast), 32'd0);
        check_vec("rs_frames", frame_count, 32'd0);
        check_vec("rs_overrun", 32'(overrun_count), 32'd0);
        tick();
        sys_reset = 1'b0;
        tick();
        fire();
        collect(4, 99, 0, 99, 99);
        check_vec("rs_frames_after", frame_count, 32'd1);

        // Zero-length trigger is ignored
        cfg_len = '0;
        fire();
        first_v = 0;
        for (int k = 0; k < 5; k++) begin
            if (m_axis_tvalid || busy) first_v++;
            tick();
        end
        check_vec("len0_activity", 32'(first_v), 32'd0);
        check_vec("len0_overrun", 32'(overrun_count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
